// File: rtl/join_pkg.sv
// Shared definitions for the stream join controller.
//   DW_DEF / DEPTH_DEF : default data width and per-stream FIFO depth
//   data_t             : one stream word at the default width
//   out_state_t        : state of the joined output register
package join_pkg;

  localparam int DW_DEF    = 11;
  localparam int DEPTH_DEF = 2;

  typedef logic [DW_DEF-1:0] data_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/join_fifo.sv
// DEPTH-entry synchronous FIFO used to buffer one input stream of the join.
// The head word is presented combinationally on o_dout (no fall-through:
// a word pushed at edge N is visible at the head only after edge N).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears pointers)
//   i_push, i_din : write request and data (ignored while full)
//   i_pop         : read request (ignored while empty)
//   o_dout        : head word
//   o_full        : no free entry
//   o_empty       : no stored entry
//   o_count       : number of stored entries, 0..DEPTH
module join_fifo
  import join_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_din,
  input  logic                   i_pop,
  output logic [DW-1:0]          o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full (MSBs differ, index equal) and
  // empty (identical) are distinguishable without a separate counter.
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign o_count   = r_wptr - r_rptr;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/stream_join_ctrl.sv
// Joins two valid/ready input streams into one stream of word pairs.
// Each input is buffered in its own join_fifo; when both heads are present
// and the output register is free (or being drained this cycle) both heads
// are popped together into the output register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   dval1, d1, rdy1 : stream 1 valid / data / ready (FIFO 1 not full)
//   dval2, d2, rdy2 : stream 2 valid / data / ready (FIFO 2 not full)
//   oval, o1, o2    : joined pair valid and words
//   ordy            : downstream ready
//   npair           : wrapping count of completed output handshakes
//   skew            : signed FIFO 1 count minus FIFO 2 count (registered)
module stream_join_ctrl
  import join_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dval1,
  input  logic [DW-1:0]                 d1,
  output logic                          rdy1,
  input  logic                          dval2,
  input  logic [DW-1:0]                 d2,
  output logic                          rdy2,
  output logic                          oval,
  output logic [DW-1:0]                 o1,
  output logic [DW-1:0]                 o2,
  input  logic                          ordy,
  output logic [15:0]                   npair,
  output logic signed [$clog2(DEPTH)+1:0] skew
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 2;

  logic          w_full1, w_full2, w_empty1, w_empty2;
  logic [AW:0]   w_cnt1, w_cnt2;
  logic [DW-1:0] w_dout1, w_dout2;
  logic          w_push1, w_push2;
  logic          w_load, w_hs;
  logic signed [SW-1:0] w_cnt1_nxt, w_cnt2_nxt;

  out_state_t           r_state;
  logic [DW-1:0]        r_o1, r_o2;
  logic [15:0]          r_npair;
  logic signed [SW-1:0] r_skew;

  // Input stage: ready depends only on FIFO fullness, never on the pop.
  assign rdy1    = !w_full1;
  assign rdy2    = !w_full2;
  assign w_push1 = dval1 && !w_full1;
  assign w_push2 = dval2 && !w_full2;

  join_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push1),
    .i_din   (d1),
    .i_pop   (w_load),
    .o_dout  (w_dout1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_count (w_cnt1)
  );

  join_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push2),
    .i_din   (d2),
    .i_pop   (w_load),
    .o_dout  (w_dout2),
    .o_full  (w_full2),
    .o_empty (w_empty2),
    .o_count (w_cnt2)
  );

  // Output stage: load whenever both heads exist and the register is free
  // or handing off its current pair this same edge.
  assign w_hs   = (r_state == ST_HELD) && ordy;
  assign w_load = !w_empty1 && !w_empty2 && ((r_state == ST_EMPTY) || ordy);

  // Skew reflects the counts as they will be after this edge, so it always
  // matches the FIFO occupancy visible in the following cycle.
  assign w_cnt1_nxt = SW'(w_cnt1) + SW'(w_push1) - SW'(w_load);
  assign w_cnt2_nxt = SW'(w_cnt2) + SW'(w_push2) - SW'(w_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_o1    <= '0;
      r_o2    <= '0;
      r_npair <= '0;
      r_skew  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_state <= ST_HELD;
            r_o1    <= w_dout1;
            r_o2    <= w_dout2;
          end
        end
        ST_HELD: begin
          if (w_load) begin
            r_o1 <= w_dout1;
            r_o2 <= w_dout2;
          end else if (ordy) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_hs) r_npair <= r_npair + 16'd1;
      r_skew <= w_cnt1_nxt - w_cnt2_nxt;
    end
  end

  assign oval  = (r_state == ST_HELD);
  assign o1    = r_o1;
  assign o2    = r_o2;
  assign npair = r_npair;
  assign skew  = r_skew;

endmodule

// File: tb/tb_stream_join_ctrl.sv
module tb_stream_join_ctrl;
  import join_pkg::*;

  localparam int DW    = DW_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int SW    = $clog2(DEPTH) + 2;

  logic clk = 1'b0;
  logic rst, dval1, dval2, rdy1, rdy2, oval, ordy;
  data_t d1, d2, o1, o2;
  logic [15:0] npair;
  logic signed [SW-1:0] skew;

  int checks = 0;
  int errors = 0;

  // Reference model: two bounded queues and a one-pair output holder.
  data_t       q1[$];
  data_t       q2[$];
  logic        m_oval;
  data_t       m_o1, m_o2;
  logic [15:0] m_npair;
  int          m_skew;

  always #5 clk = ~clk;

  stream_join_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .dval1 (dval1),
    .d1    (d1),
    .rdy1  (rdy1),
    .dval2 (dval2),
    .d2    (d2),
    .rdy2  (rdy2),
    .oval  (oval),
    .o1    (o1),
    .o2    (o2),
    .ordy  (ordy),
    .npair (npair),
    .skew  (skew)
  );

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_oval  = 1'b0;
    m_o1    = '0;
    m_o2    = '0;
    m_npair = '0;
    m_skew  = 0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit acc1, acc2, ld, hs;
    if (rst) begin
      model_reset();
      return;
    end
    acc1 = dval1 && (q1.size() < DEPTH);
    acc2 = dval2 && (q2.size() < DEPTH);
    ld   = (q1.size() > 0) && (q2.size() > 0) && (!m_oval || ordy);
    hs   = m_oval && ordy;
    if (ld) begin
      m_o1   = q1.pop_front();
      m_o2   = q2.pop_front();
      m_oval = 1'b1;
    end else if (hs) begin
      m_oval = 1'b0;
    end
    if (hs) m_npair = m_npair + 16'd1;
    if (acc1) q1.push_back(d1);
    if (acc2) q2.push_back(d2);
    m_skew = q1.size() - q2.size();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0; d1 = '0; d2 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dval1 = 1'b1; dval2 = 1'b1; d1 = 11'h3A5; d2 = 11'h15A; ordy = 1'b1;
    tick();
    tick();
    checks++; if (oval !== 1'b0) begin errors++; $display("FAIL reset_oval got %0b exp 0", oval); end
    checks++; if (o1 !== '0 || o2 !== '0) begin errors++; $display("FAIL reset_odata got %h/%h exp 0/0", o1, o2); end
    checks++; if (npair !== 16'd0) begin errors++; $display("FAIL reset_npair got %0d exp 0", npair); end
    checks++; if (skew !== '0) begin errors++; $display("FAIL reset_skew got %0d exp 0", skew); end
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b%0b exp 11", rdy1, rdy2); end
    rst = 1'b0; dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0;
    tick();
    checks++; if (oval !== 1'b0 || skew !== '0) begin errors++; $display("FAIL reset_discard got oval=%0b skew=%0d exp 0/0", oval, skew); end
  endtask

  task automatic test_basic();
    do_reset();
    d1 = 11'h001; d2 = 11'h7FF; dval1 = 1'b1; dval2 = 1'b1; ordy = 1'b1;
    tick();
    dval1 = 1'b0; dval2 = 1'b0;
    checks++; if (oval !== 1'b0) begin errors++; $display("FAIL basic_lat0 got oval=%0b exp 0", oval); end
    tick();
    checks++; if (oval !== 1'b1) begin errors++; $display("FAIL basic_oval got %0b exp 1", oval); end
    checks++; if (o1 !== 11'h001 || o2 !== 11'h7FF) begin errors++; $display("FAIL basic_data got %h/%h exp 001/7ff", o1, o2); end
    tick();
    checks++; if (npair !== 16'd1 || oval !== 1'b0) begin errors++; $display("FAIL basic_npair got %0d oval=%0b exp 1/0", npair, oval); end
  endtask

  task automatic test_fill();
    data_t w[3];
    int idx;
    bit was_rdy;
    w[0] = 11'h010; w[1] = 11'h011; w[2] = 11'h012;
    do_reset();
    ordy = 1'b1; dval1 = 1'b1; idx = 0;
    for (int c = 0; c < 4; c++) begin
      d1 = w[idx];
      was_rdy = rdy1;
      tick();
      if (was_rdy && idx < 2) idx++;
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL fill_accepts got %0d exp 2", idx); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL fill_rdy1 got %0b exp 0", rdy1); end
    checks++; if (skew !== SW'(2)) begin errors++; $display("FAIL fill_skew got %0d exp 2", skew); end
    checks++; if (oval !== 1'b0) begin errors++; $display("FAIL fill_oval got %0b exp 0", oval); end
    // Stream 2 now supplies its words; pairs must use the first two stream 1 words.
    dval2 = 1'b1; d2 = 11'h055;
    tick();
    dval2 = 1'b0;
    tick();
    checks++; if (oval !== 1'b1 || o1 !== 11'h010 || o2 !== 11'h055) begin errors++; $display("FAIL fill_pair got %0b %h/%h exp 1 010/055", oval, o1, o2); end
    dval1 = 1'b0;
  endtask

  task automatic test_toggle();
    data_t w1[8], w2[8];
    int a1, a2, got, cyc;
    bit take1, take2, prev_hold;
    data_t p1, p2;
    for (int i = 0; i < 8; i++) begin
      w1[i] = data_t'($urandom);
      w2[i] = data_t'($urandom);
    end
    do_reset();
    a1 = 0; a2 = 0; got = 0; cyc = 0; prev_hold = 1'b0; p1 = '0; p2 = '0;
    while (got < 8 && cyc < 60) begin
      dval1 = (a1 < 8); d1 = w1[a1 < 8 ? a1 : 7];
      dval2 = (a2 < 8); d2 = w2[a2 < 8 ? a2 : 7];
      ordy  = ~cyc[0];
      if (prev_hold) begin
        checks++; if (o1 !== p1 || o2 !== p2) begin errors++; $display("FAIL toggle_stable got %h/%h exp %h/%h", o1, o2, p1, p2); end
      end
      if (oval && ordy) begin
        checks++; if (o1 !== w1[got] || o2 !== w2[got]) begin errors++; $display("FAIL toggle_order pair %0d got %h/%h exp %h/%h", got, o1, o2, w1[got], w2[got]); end
        got++;
      end
      prev_hold = oval && !ordy; p1 = o1; p2 = o2;
      take1 = dval1 && rdy1; take2 = dval2 && rdy2;
      tick();
      if (take1) a1++;
      if (take2) a2++;
      cyc++;
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL toggle_count got %0d exp 8", got); end
    checks++; if (npair !== 16'd8) begin errors++; $display("FAIL toggle_npair got %0d exp 8", npair); end
    dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ordy = 1'b0;
    dval1 = 1'b1; dval2 = 1'b1; d1 = 11'h001; d2 = 11'h002;
    tick();
    dval2 = 1'b0; d1 = 11'h003;
    tick();
    d1 = 11'h004;
    tick();
    dval1 = 1'b0;
    tick();
    checks++; if (oval !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL rmid_pre got oval=%0b rdy1=%0b exp 1/0", oval, rdy1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (oval !== 1'b0 || skew !== '0 || rdy1 !== 1'b1) begin errors++; $display("FAIL rmid_async got oval=%0b skew=%0d rdy1=%0b exp 0/0/1", oval, skew, rdy1); end
    dval1 = 1'b1; d1 = 11'h7FF;
    tick();
    rst = 1'b0;
    d1 = 11'h02A; d2 = 11'h015; dval1 = 1'b1; dval2 = 1'b1; ordy = 1'b1;
    tick();
    dval1 = 1'b0; dval2 = 1'b0;
    tick();
    checks++; if (oval !== 1'b1 || o1 !== 11'h02A || o2 !== 11'h015) begin errors++; $display("FAIL rmid_pair got %0b %h/%h exp 1 02a/015", oval, o1, o2); end
    ordy = 1'b0;
  endtask

  task automatic test_random();
    logic signed [SW-1:0] e_skew;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      dval1 = ($urandom_range(0, 3) != 0);
      dval2 = ($urandom_range(0, 3) != 0);
      d1 = data_t'($urandom);
      d2 = data_t'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      tick();
      e_skew = SW'(m_skew);
      checks++; if (oval !== m_oval) begin errors++; $display("FAIL rand_oval c=%0d got %0b exp %0b", c, oval, m_oval); end
      checks++; if (o1 !== m_o1 || o2 !== m_o2) begin errors++; $display("FAIL rand_data c=%0d got %h/%h exp %h/%h", c, o1, o2, m_o1, m_o2); end
      checks++; if (npair !== m_npair) begin errors++; $display("FAIL rand_npair c=%0d got %0d exp %0d", c, npair, m_npair); end
      checks++; if (skew !== e_skew) begin errors++; $display("FAIL rand_skew c=%0d got %0d exp %0d", c, skew, e_skew); end
      checks++; if (rdy1 !== (q1.size() < DEPTH) || rdy2 !== (q2.size() < DEPTH)) begin errors++; $display("FAIL rand_rdy c=%0d got %0b%0b exp %0b%0b", c, rdy1, rdy2, q1.size() < DEPTH, q2.size() < DEPTH); end
    end
    dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    dval1 = 1'b1; dval2 = 1'b1; d1 = 11'h123; d2 = 11'h456; ordy = 1'b1;
    cyc = 0;
    while (m_npair != 16'hFFFF && cyc < 70000) begin
      tick();
      cyc++;
    end
    checks++; if (npair !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %0d exp 65535", npair); end
    cyc = 0;
    while (m_npair == 16'hFFFF && cyc < 5) begin
      tick();
      cyc++;
    end
    checks++; if (npair !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %0d exp 0", npair); end
    dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dval1 = 1'b0; dval2 = 1'b0; ordy = 1'b0; d1 = '0; d2 = '0;
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_toggle();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
